// File: rtl/ppu_retire_trace_buffer.sv
// Purpose : classify retired instructions, count per class, queue {[ts],class,pc,instr} trace records.
// Latency : 1 cycle from retire to trace_valid_o (no bypass); counters update at the next edge.
// Backpr. : trace_ready_i stalls the FIFO head; a push into a full FIFO without a same-cycle pop is dropped and counted.
//
// Ports: clk, rst_n (async active-low); instr_valid_i/instr_rdata_i/pc_i retire stream;
//        clear_i sync clear; trace_valid_o/trace_ready_i/trace_data_o sink handshake;
//        class_cnt_o (8 x CNT_W), drop_cnt_o (saturating), overflow_o (sticky).
// Optional: define TRACE_TIMESTAMP_EN to prepend a TS_W-bit cycle stamp to every record.
module ppu_retire_trace_buffer #(
    parameter int DEPTH           = 8,
    parameter int CNT_W           = 32,
    parameter bit FILTER_PPU_ONLY = 1'b0,
    parameter int TS_W            = 32,
`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W          = TS_W + 67
`else
    localparam int REC_W          = 67
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid_i,
    input  logic [31:0]        instr_rdata_i,
    input  logic [31:0]        pc_i,
    input  logic               clear_i,
    output logic               trace_valid_o,
    input  logic               trace_ready_i,
    output logic [REC_W-1:0]   trace_data_o,
    output logic [8*CNT_W-1:0] class_cnt_o,
    output logic [CNT_W-1:0]   drop_cnt_o,
    output logic               overflow_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] OPC_PPU_OP = 7'b0001011;  // custom-0
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_PPU     = 7'b1101010;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_param
        $error("ppu_retire_trace_buffer: DEPTH must be a power of two >= 2 and TS_W >= 1");
    end

    // ---------------- classification (first match wins) ----------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [2:0] cls;

    assign opcode = instr_rdata_i[6:0];
    assign funct3 = instr_rdata_i[14:12];
    assign funct7 = instr_rdata_i[31:25];

    always_comb begin
        cls = 3'd0;
        if (opcode == OPC_PPU_OP) begin
            // PPU opcode with an unknown funct3/funct7 deliberately falls to OTHER
            if (funct7 == F7_PPU) begin
                case (funct3)
                    3'b000:  cls = 3'd1;
                    3'b001:  cls = 3'd2;
                    3'b010:  cls = 3'd3;
                    3'b100:  cls = 3'd4;
                    default: cls = 3'd0;
                endcase
            end
        end else if (opcode == OPC_OP && funct7 == F7_MULDIV) begin
            cls = 3'd5;
        end else if (opcode == OPC_BRANCH) begin
            cls = 3'd6;
        end else if (opcode == OPC_SYSTEM) begin
            cls = 3'd7;
        end
    end

    // ---------------- FIFO control ----------------
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop, do_write, do_drop;
    logic [REC_W-1:0] mem [DEPTH];
    logic [REC_W-1:0] rec_in;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push     = instr_valid_i && (!FILTER_PPU_ONLY || (cls >= 3'd1 && cls <= 3'd4));
    assign pop      = !empty && trace_ready_i;
    // A same-cycle pop frees the slot the push needs, so a full FIFO still accepts it.
    assign do_write = push && (!full || pop);
    assign do_drop  = push && full && !pop;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (clear_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign rec_in = {ts_q, cls, pc_i, instr_rdata_i};
`else
    assign rec_in = {cls, pc_i, instr_rdata_i};
`endif

    // Storage carries no reset; the output is gated by empty instead.
    always_ff @(posedge clk) begin
        if (do_write && !clear_i) begin
            mem[wr_ptr[AW-1:0]] <= rec_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign trace_valid_o = !empty;
    assign trace_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // ---------------- counters and loss accounting ----------------
    logic [CNT_W-1:0] cnt [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) cnt[k] <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            for (int k = 0; k < 8; k++) cnt[k] <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (instr_valid_i) cnt[cls] <= cnt[cls] + CNT_W'(1);
            if (do_drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_cnt_out
        assign class_cnt_o[g*CNT_W +: CNT_W] = cnt[g];
    end

endmodule

// File: tb/tb_ppu_retire_trace_buffer.sv
// Bench for ppu_retire_trace_buffer: instance a is the default build (DEPTH 8, CNT_W 32, unfiltered),
// instance b shares the retire stream but is PPU-filtered with DEPTH 2 and CNT_W 2 so that
// filtering, counter wrap and drop-count saturation show up within a few records.
module tb_ppu_retire_trace_buffer;

`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_A = 32 + 67;
    localparam int REC_B = 32 + 67;
`else
    localparam int REC_A = 67;
    localparam int REC_B = 67;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr_rdata;
    logic [31:0] pc;
    logic        clear;
    logic        ready_a, ready_b;

    logic             valid_a, valid_b;
    logic [REC_A-1:0] data_a;
    logic [REC_B-1:0] data_b;
    logic [255:0]     cnt_a;
    logic [15:0]      cnt_b;
    logic [31:0]      drop_a;
    logic [1:0]       drop_b;
    logic             ovf_a, ovf_b;

    ppu_retire_trace_buffer #(.DEPTH(8), .CNT_W(32), .FILTER_PPU_ONLY(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_rdata_i(instr_rdata),
        .pc_i(pc), .clear_i(clear), .trace_valid_o(valid_a), .trace_ready_i(ready_a),
        .trace_data_o(data_a), .class_cnt_o(cnt_a), .drop_cnt_o(drop_a), .overflow_o(ovf_a));

    ppu_retire_trace_buffer #(.DEPTH(2), .CNT_W(2), .FILTER_PPU_ONLY(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_rdata_i(instr_rdata),
        .pc_i(pc), .clear_i(clear), .trace_valid_o(valid_b), .trace_ready_i(ready_b),
        .trace_data_o(data_b), .class_cnt_o(cnt_b), .drop_cnt_o(drop_b), .overflow_o(ovf_b));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops_a = 0;
    int pops_b = 0;

    logic [66:0] qa[$];
    logic [66:0] qb[$];

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake seen here completes at the following rising edge.
    always @(negedge clk) begin
        if (rst_n && valid_a && ready_a) begin
            pops_a++;
            if (qa.size() == 0) check("a_unexpected_record", data_a[66:0], 67'h0 - 67'h1);
            else check("a_record", data_a[66:0], qa.pop_front());
        end
        if (rst_n && valid_b && ready_b) begin
            pops_b++;
            if (qb.size() == 0) check("b_unexpected_record", data_b[66:0], 67'h0 - 67'h1);
            else check("b_record", data_b[66:0], qb.pop_front());
        end
    end

    function automatic logic [31:0] ppu(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 10'h0, f3, 5'h0, 7'b0001011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] ins, input logic [31:0] p, input logic [2:0] c,
                          input bit pa, input bit pb);
        instr_valid = 1'b1;
        instr_rdata = ins;
        pc          = p;
        if (pa) qa.push_back({c, p, ins});
        if (pb) qb.push_back({c, p, ins});
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear       = 1'b1;
        instr_valid = 1'b1;
        instr_rdata = ppu(7'b1101010, 3'b000);
        pc          = 32'hdead;
        tick();
        clear       = 1'b0;
        instr_valid = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    function automatic logic [31:0] ca(input int k);
        return cnt_a[k*32 +: 32];
    endfunction

    function automatic logic [1:0] cb(input int k);
        return cnt_b[k*2 +: 2];
    endfunction

    task automatic drain(input string name);
        ready_a = 1'b1;
        ready_b = 1'b1;
        for (int i = 0; i < 20 && (valid_a || valid_b); i++) tick();
        total++;
        if (valid_a || valid_b) begin
            bad++;
            $display("FAIL %s_timeout: valid_a=%0d valid_b=%0d expected both 0", name, valid_a, valid_b);
        end
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    localparam logic [6:0] F7P = 7'b1101010;

    initial begin
        int snap;
        rst_n = 1'b0; instr_valid = 1'b0; instr_rdata = '0; pc = '0;
        clear = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: reset state
        check("rst_valid_a", 67'(valid_a), 67'd0);
        check("rst_cnt_a",   67'(cnt_a == '0), 67'd1);
        check("rst_drop_a",  67'(drop_a), 67'd0);
        check("rst_ovf_a",   67'(ovf_a), 67'd0);
        check("rst_valid_b", 67'(valid_b), 67'd0);

        // 2: PPU_MUL at 0x100 visible next cycle
        retire(ppu(F7P, 3'b010), 32'h100, 3'd3, 1'b1, 1'b1);
        check("mul_valid_a", 67'(valid_a), 67'd1);
        check("mul_class_a", 67'(data_a[66:64]), 67'd3);
        check("mul_pc_a",    67'(data_a[63:32]), 67'h100);
        check("mul_cnt3_a",  67'(ca(3)), 67'd1);
        ready_a = 1'b1; ready_b = 1'b1;
        tick();
        ready_a = 1'b0; ready_b = 1'b0;
        check("mul_drained_a", 67'(valid_a), 67'd0);
        do_clear();

        // 3: ten PPU_ADD with the sink stalled
        for (int i = 0; i < 10; i++)
            retire(ppu(F7P, 3'b000), 32'h200 + 32'(4*i), 3'd1, i < 8, i < 2);
        check("fill_drop_a", 67'(drop_a), 67'd2);
        check("fill_ovf_a",  67'(ovf_a), 67'd1);
        check("fill_cnt1_a", 67'(ca(1)), 67'd10);
        check("fill_drop_b_sat", 67'(drop_b), 67'd3);
        check("fill_ovf_b",  67'(ovf_b), 67'd1);
        check("fill_cnt1_b_wrap", 67'(cb(1)), 67'd2);

        // 4: push into full FIFO with a same-cycle pop
        ready_a = 1'b1;
        retire(ppu(F7P, 3'b001), 32'h300, 3'd2, 1'b1, 1'b0);
        ready_a = 1'b0;
        check("full_pushpop_drop_a", 67'(drop_a), 67'd2);
        check("full_pushpop_drop_b", 67'(drop_b), 67'd3);
        check("full_pushpop_cnt2_b", 67'(cb(2)), 67'd1);
        snap = pops_a;
        drain("full_drain");
        check("full_occupancy_a", 67'(pops_a - snap), 67'd8);
        check("full_order_done_a", 67'(qa.size()), 67'd0);
        do_clear();

        // 5: classification and filter, sink always ready
        ready_a = 1'b1; ready_b = 1'b1;
        retire(32'h00208033, 32'h500, 3'd0, 1'b1, 1'b0);          // ADD
        retire(32'h0220C1B3, 32'h504, 3'd5, 1'b1, 1'b0);          // DIV
        retire(ppu(F7P, 3'b001), 32'h508, 3'd2, 1'b1, 1'b1);      // PPU_SUB
        tick();
        check("filt_cnt0_b", 67'(cb(0)), 67'd1);
        check("filt_cnt5_b", 67'(cb(5)), 67'd1);
        check("filt_cnt2_b", 67'(cb(2)), 67'd1);
        retire(32'h00000063, 32'h50c, 3'd6, 1'b1, 1'b0);          // BEQ
        retire(32'h00000073, 32'h510, 3'd7, 1'b1, 1'b0);          // ECALL
        retire(ppu(F7P, 3'b011), 32'h514, 3'd0, 1'b1, 1'b0);      // PPU bad funct3
        retire(ppu(7'b0000000, 3'b000), 32'h518, 3'd0, 1'b1, 1'b0); // PPU bad funct7
        retire(ppu(F7P, 3'b100), 32'h51c, 3'd4, 1'b1, 1'b1);      // PPU_DIV
        tick();
        check("cls_cnt0_a", 67'(ca(0)), 67'd3);
        check("cls_cnt6_a", 67'(ca(6)), 67'd1);
        check("cls_cnt7_a", 67'(ca(7)), 67'd1);
        check("cls_cnt4_a", 67'(ca(4)), 67'd1);
        check("cls_drop_a", 67'(drop_a), 67'd0);
        ready_a = 1'b0; ready_b = 1'b0;
        check("cls_done_a", 67'(qa.size()), 67'd0);
        check("cls_done_b", 67'(qb.size()), 67'd0);
        do_clear();

        // 6: clear with a same-cycle retire while holding records
        for (int i = 0; i < 3; i++)
            retire(ppu(F7P, 3'b100), 32'h400 + 32'(4*i), 3'd4, 1'b1, i < 2);
        check("pre_clr_ovf_b", 67'(ovf_b), 67'd1);
        do_clear();
        check("clr_valid_a", 67'(valid_a), 67'd0);
        check("clr_cnt_a",   67'(cnt_a == '0), 67'd1);
        check("clr_cnt_b",   67'(cnt_b), 67'd0);
        check("clr_ovf_b",   67'(ovf_b), 67'd0);
        check("clr_drop_b",  67'(drop_b), 67'd0);

        // 7: reset mid-transfer drops valid immediately
        retire(ppu(F7P, 3'b000), 32'h600, 3'd1, 1'b1, 1'b1);
        check("pre_rst_valid_a", 67'(valid_a), 67'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid_a", 67'(valid_a), 67'd0);
        check("async_rst_cnt_a",   67'(ca(1)), 67'd0);
        qa.delete();
        qb.delete();
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_valid_b", 67'(valid_b), 67'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
